alu_exec_unit: RTL

Handshaked, registered execute unit that sits on the consuming side of the ALU decoder. It accepts an `ALUControl` code with two 32-bit operands and computes result, zero, overflow and illegal-op flags. Results are held in a 2-entry output buffer so a stalled consumer (writeback, or a bench monitor) never loses one. It is the step from our single-cycle datapath toward a decoupled execute stage.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_core.sv | 51 +++++
 rtl/alu_exec_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings used by the decoder and the execute unit.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   function automatic logic uses_sub(logic [2:0] ctrl);
      return (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus zero, signed-overflow and illegal flags.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       ctrl_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             ovf_o,
   output logic             err_o
);

   localparam int M = WIDTH - 1;

   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic             v;

   assign sub   = uses_sub(ctrl_i);
   assign b_eff = sub ? ~b_i : b_i;
   assign sum   = a_i + b_eff + {{(WIDTH-1){1'b0}}, sub};
   // Same rule covers add and sub once B has been conditionally inverted.
   assign v     = (a_i[M] == b_eff[M]) && (sum[M] != a_i[M]);

   always_comb begin
      result_o = '0;
      ovf_o    = 1'b0;
      err_o    = 1'b0;
      unique case (ctrl_i)
         ALU_ADD: begin
            result_o = sum;
            ovf_o    = v;
         end
         ALU_SUB: begin
            result_o = sum;
            ovf_o    = v;
         end
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, sum[M] ^ v};
         default: err_o = 1'b1;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked execute stage: ALU core feeding a 2-entry result FIFO.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_ovf,
   output logic             out_err,
   output logic [CNT_W-1:0] ops_done
);

   logic [WIDTH-1:0] core_res;
   logic             core_zero;
   logic             core_ovf;
   logic             core_err;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a_i      (SrcA),
      .b_i      (SrcB),
      .ctrl_i   (ALUControl),
      .result_o (core_res),
      .zero_o   (core_zero),
      .ovf_o    (core_ovf),
      .err_o    (core_err)
   );

   logic [1:0][WIDTH-1:0] res_q;
   logic [1:0]            zero_q;
   logic [1:0]            ovf_q;
   logic [1:0]            err_q;
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            count_q;
   logic [1:0]            count_d;
   logic [CNT_W-1:0]      ops_q;
   logic                  push;
   logic                  pop;

   // Ready depends on occupancy only, so out_ready never reaches in_ready.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q    <= '0;
         zero_q   <= '0;
         ovf_q    <= '0;
         err_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
         ops_q    <= '0;
      end else begin
         if (push) begin
            res_q[wr_ptr_q]  <= core_res;
            zero_q[wr_ptr_q] <= core_zero;
            ovf_q[wr_ptr_q]  <= core_ovf;
            err_q[wr_ptr_q]  <= core_err;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
            ops_q    <= ops_q + CNT_W'(1);
         end
         count_q <= count_d;
      end
   end

   assign out_result = res_q[rd_ptr_q];
   assign out_zero   = zero_q[rd_ptr_q];
   assign out_ovf    = ovf_q[rd_ptr_q];
   assign out_err    = err_q[rd_ptr_q];
   assign ops_done   = ops_q;

endmodule
